ppu_sprite_eval_fsm: RTL and testbench

Upstream stage of the PPU tile loader: for each 8-pixel tile about to be rendered, scans OAM and selects up to two sprites covering the current row and overlapping the tile's column span. Delivers their cached Y/tile/attr/X bytes and on-tile flags to `ppu_vram_load_fsm`, and pulses `done` so the tile sequencer can launch the VRAM load. OAM priority is preserved: the lower OAM index always lands in slot 0.

---
 rtl/ppu_sprite_eval_fsm_if.sv | 43 ++++
 rtl/ppu_sprite_eval_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_ppu_sprite_eval_fsm.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_sprite_eval_fsm_if.sv
// Sprite-evaluation port bundle: tile request, OAM read bus, two result slots and status.
// master = tile sequencer / OAM side, slave = ppu_sprite_eval_fsm.
interface ppu_sprite_eval_fsm_if;
    logic       start;
    logic [8:0] curr_row;
    logic [8:0] curr_col;
    logic [7:0] ppu_ctrl1;

    logic [7:0] oam_addr;
    logic [7:0] oam_data;

    logic       sprite_0_on_tile;
    logic [7:0] sprite_0_row;
    logic [7:0] sprite_0_tile_num;
    logic [7:0] sprite_0_attr;
    logic [7:0] sprite_0_col;
    logic       sprite_1_on_tile;
    logic [7:0] sprite_1_row;
    logic [7:0] sprite_1_tile_num;
    logic [7:0] sprite_1_attr;
    logic [7:0] sprite_1_col;

    logic       sprite_0_is_oam0;
    logic       sprite_overflow;
    logic       busy;
    logic       done;

    modport master (
        output start, curr_row, curr_col, ppu_ctrl1, oam_data,
        input  oam_addr,
        input  sprite_0_on_tile, sprite_0_row, sprite_0_tile_num, sprite_0_attr, sprite_0_col,
        input  sprite_1_on_tile, sprite_1_row, sprite_1_tile_num, sprite_1_attr, sprite_1_col,
        input  sprite_0_is_oam0, sprite_overflow, busy, done
    );

    modport slave (
        input  start, curr_row, curr_col, ppu_ctrl1, oam_data,
        output oam_addr,
        output sprite_0_on_tile, sprite_0_row, sprite_0_tile_num, sprite_0_attr, sprite_0_col,
        output sprite_1_on_tile, sprite_1_row, sprite_1_tile_num, sprite_1_attr, sprite_1_col,
        output sprite_0_is_oam0, sprite_overflow, busy, done
    );
endinterface

// File: rtl/ppu_sprite_eval_fsm.sv
// Per-tile OAM scan keeping the first two sprites that cover curr_row and overlap the
// 8-pixel tile at curr_col. Define SPRITE_OVERFLOW_EN to keep scanning and flag a third hit.
module ppu_sprite_eval_fsm #(
    parameter int NUM_SPRITES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    ppu_sprite_eval_fsm_if.slave sif
);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    typedef enum logic [2:0] {IDLE, RD_Y, RD_X, RD_T, RD_A} state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] n_reg, n_next, n_inc;
    logic [1:0]    count_reg, count_next;
    logic [7:0]    oam_addr_reg, oam_addr_next;
    logic [7:0]    y_reg, y_next;
    logic [7:0]    x_reg, x_next;
    logic [7:0]    tile_reg, tile_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          is_oam0_reg, is_oam0_next;
    logic          overflow_reg, overflow_next;

    logic          slot_clear;
    logic [1:0]    slot_load;
    logic          do_advance, do_finish;
    logic          last_sprite;
    logic [7:0]    entry_base, next_base;

    logic [9:0]         dy;
    logic signed [10:0] col_s, x_s;
    logic               y_hit, x_hit;
    logic               unused_ctrl_bits;

    assign n_inc       = n_reg + IW'(1);
    assign last_sprite = (n_reg == IW'(NUM_SPRITES - 1));
    assign entry_base  = 8'({n_reg, 2'b00});
    assign next_base   = 8'({n_inc, 2'b00});

    // Row test relies on 10-bit wrap: a sprite below the row gives a huge dy and misses.
    assign dy    = {1'b0, sif.curr_row} - {2'b00, y_reg};
    assign y_hit = dy < (sif.ppu_ctrl1[5] ? 10'd16 : 10'd8);

    assign col_s = {{2{sif.curr_col[8]}}, sif.curr_col};
    assign x_s   = {3'b000, sif.oam_data};
    assign x_hit = (x_s <= col_s + 11'sd7) && (x_s + 11'sd7 >= col_s);

    assign unused_ctrl_bits = ^{sif.ppu_ctrl1[7:6], sif.ppu_ctrl1[4:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            n_reg        <= '0;
            count_reg    <= '0;
            oam_addr_reg <= '0;
            y_reg        <= '0;
            x_reg        <= '0;
            tile_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            is_oam0_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            n_reg        <= n_next;
            count_reg    <= count_next;
            oam_addr_reg <= oam_addr_next;
            y_reg        <= y_next;
            x_reg        <= x_next;
            tile_reg     <= tile_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            is_oam0_reg  <= is_oam0_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        count_next    = count_reg;
        oam_addr_next = oam_addr_reg;
        y_next        = y_reg;
        x_next        = x_reg;
        tile_next     = tile_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        is_oam0_next  = is_oam0_reg;
        overflow_next = overflow_reg;
        slot_clear    = 1'b0;
        slot_load     = 2'b00;
        do_advance    = 1'b0;
        do_finish     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sif.start) begin
                    slot_clear    = 1'b1;
                    is_oam0_next  = 1'b0;
                    overflow_next = 1'b0;
                    n_next        = '0;
                    count_next    = '0;
                    oam_addr_next = 8'h00;
                    busy_next     = 1'b1;
                    state_next    = RD_Y;
                end
            end
            RD_Y: begin
                y_next        = sif.oam_data;
                oam_addr_next = entry_base | 8'd3;
                state_next    = RD_X;
            end
            RD_X: begin
                x_next = sif.oam_data;
                if (y_hit && x_hit) begin
                    if (count_reg < 2'd2) begin
                        oam_addr_next = entry_base | 8'd1;
                        state_next    = RD_T;
                    end else begin
`ifdef SPRITE_OVERFLOW_EN
                        overflow_next = 1'b1;
`endif
                        do_finish = 1'b1;
                    end
                end else begin
                    do_advance = 1'b1;
                end
            end
            RD_T: begin
                tile_next     = sif.oam_data;
                oam_addr_next = entry_base | 8'd2;
                state_next    = RD_A;
            end
            RD_A: begin
                slot_load[count_reg[0]] = 1'b1;
                if (count_reg == 2'd0 && n_reg == '0)
                    is_oam0_next = 1'b1;
                count_next = count_reg + 2'd1;
`ifdef SPRITE_OVERFLOW_EN
                do_advance = 1'b1;
`else
                if (count_reg == 2'd1)
                    do_finish = 1'b1;
                else
                    do_advance = 1'b1;
`endif
            end
            default: state_next = IDLE;
        endcase

        if (do_advance && !last_sprite) begin
            n_next        = n_inc;
            oam_addr_next = next_base;
            state_next    = RD_Y;
        end
        if (do_finish || (do_advance && last_sprite)) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
        end
    end

    // Result slots: slot index equals hit order, so OAM priority is kept.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic       slot_on_reg;
            logic [7:0] slot_row_reg, slot_tile_reg, slot_attr_reg, slot_col_reg;

            always_ff @(posedge clk) begin
                if (rst || slot_clear) begin
                    slot_on_reg   <= 1'b0;
                    slot_row_reg  <= '0;
                    slot_tile_reg <= '0;
                    slot_attr_reg <= '0;
                    slot_col_reg  <= '0;
                end else if (slot_load[gi]) begin
                    slot_on_reg   <= 1'b1;
                    slot_row_reg  <= y_reg;
                    slot_tile_reg <= tile_reg;
                    slot_attr_reg <= sif.oam_data;
                    slot_col_reg  <= x_reg;
                end
            end
        end
    endgenerate

    assign sif.oam_addr          = oam_addr_reg;
    assign sif.busy              = busy_reg;
    assign sif.done              = done_reg;
    assign sif.sprite_0_is_oam0  = is_oam0_reg;
    assign sif.sprite_overflow   = overflow_reg;

    assign sif.sprite_0_on_tile  = g_slot[0].slot_on_reg;
    assign sif.sprite_0_row      = g_slot[0].slot_row_reg;
    assign sif.sprite_0_tile_num = g_slot[0].slot_tile_reg;
    assign sif.sprite_0_attr     = g_slot[0].slot_attr_reg;
    assign sif.sprite_0_col      = g_slot[0].slot_col_reg;
    assign sif.sprite_1_on_tile  = g_slot[1].slot_on_reg;
    assign sif.sprite_1_row      = g_slot[1].slot_row_reg;
    assign sif.sprite_1_tile_num = g_slot[1].slot_tile_reg;
    assign sif.sprite_1_attr     = g_slot[1].slot_attr_reg;
    assign sif.sprite_1_col      = g_slot[1].slot_col_reg;
endmodule

// File: tb/tb_ppu_sprite_eval_fsm.sv
// Bench for ppu_sprite_eval_fsm: directed corner cases plus random OAM contents,
// checked against a per-sprite cost/selection model of the scan.
module tb_ppu_sprite_eval_fsm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ppu_sprite_eval_fsm_if sif();
    ppu_sprite_eval_fsm #(.NUM_SPRITES(64)) dut (.clk(clk), .rst(rst), .sif(sif));

    logic [7:0] oam [256];
    assign sif.oam_data = oam[sif.oam_addr];

    int tests  = 0;
    int failed = 0;

    int exp_cyc;
    int exp_hits;
    int exp_idx [2];
    bit exp_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
    endtask

    task automatic put(input int n, input int y, input int t, input int a, input int x);
        oam[4*n]   = 8'(y);
        oam[4*n+1] = 8'(t);
        oam[4*n+2] = 8'(a);
        oam[4*n+3] = 8'(x);
    endtask

    // Miss costs 2 cycles, kept hit 4, overflow hit ends the scan after its 2 cycles.
    task automatic ref_model(input int row, input int col, input bit tall);
        int h, cyc, hits, y, x;
        bit hit;
        h = tall ? 16 : 8;
        cyc = 1;
        hits = 0;
        exp_ovf = 1'b0;
        exp_idx[0] = -1;
        exp_idx[1] = -1;
        for (int n = 0; n < 64; n++) begin
            y = int'(oam[4*n]);
            x = int'(oam[4*n+3]);
            hit = (row - y >= 0) && (row - y < h) && (x <= col + 7) && (x + 7 >= col);
            if (!hit) begin
                cyc += 2;
                continue;
            end
            if (hits < 2) begin
                exp_idx[hits] = n;
                hits++;
                cyc += 4;
`ifndef SPRITE_OVERFLOW_EN
                if (hits == 2) break;
`endif
            end else begin
                exp_ovf = 1'b1;
                cyc += 2;
                break;
            end
        end
        exp_cyc  = cyc;
        exp_hits = hits;
    endtask

    task automatic run_scan(input string tag, input int row, input int col, input bit tall,
                            input bit chain_in, input bit chain_out);
        int cyc, busy_bad;
        logic [7:0] obs_s [2][4];
        logic [7:0] exp_b;
        sif.curr_row  = 9'(row);
        sif.curr_col  = 9'(col);
        sif.ppu_ctrl1 = (8'($urandom) & 8'hDF) | (tall ? 8'h20 : 8'h00);
        ref_model(row, col, tall);
        if (!chain_in) begin
            @(negedge clk);
            sif.start = 1'b1;
        end
        @(posedge clk); #1;
        sif.start = 1'b0;
        cyc = 1;
        busy_bad = 0;
        while (!sif.done && cyc <= 400) begin
            if (sif.busy !== 1'b1) busy_bad++;
            sif.start = (cyc == 5);
            @(posedge clk); #1;
            cyc++;
        end
        sif.start = 1'b0;
        chk({tag, " done_cycle"}, cyc, exp_cyc);
        chk({tag, " busy_gaps"}, busy_bad, 0);
        chk({tag, " busy_at_done"}, sif.busy, 0);
        chk({tag, " on_tile0"}, sif.sprite_0_on_tile, exp_hits > 0);
        chk({tag, " on_tile1"}, sif.sprite_1_on_tile, exp_hits > 1);
        chk({tag, " is_oam0"}, sif.sprite_0_is_oam0, exp_idx[0] == 0);
        chk({tag, " overflow"}, sif.sprite_overflow, exp_ovf);
        obs_s[0][0] = sif.sprite_0_row;  obs_s[0][1] = sif.sprite_0_tile_num;
        obs_s[0][2] = sif.sprite_0_attr; obs_s[0][3] = sif.sprite_0_col;
        obs_s[1][0] = sif.sprite_1_row;  obs_s[1][1] = sif.sprite_1_tile_num;
        obs_s[1][2] = sif.sprite_1_attr; obs_s[1][3] = sif.sprite_1_col;
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < 4; b++) begin
                exp_b = (exp_idx[s] >= 0) ? oam[4*exp_idx[s] + b] : 8'h00;
                chk($sformatf("%s slot%0d byte%0d", tag, s, b), obs_s[s][b], exp_b);
            end
        end
        $display("[TB] %s: row %0d col %0d h%0d done@%0d (exp %0d) hits %0d ovf %0b",
                 tag, row, col, tall ? 16 : 8, cyc, exp_cyc, exp_hits, exp_ovf);
        if (chain_out) begin
            sif.start = 1'b1;
        end else begin
            @(posedge clk); #1;
            chk({tag, " done_pulse_len"}, sif.done, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int row, col, y, x;
        bit tall;

        rst = 1'b1;
        sif.start = 1'b0;
        sif.curr_row = '0;
        sif.curr_col = '0;
        sif.ppu_ctrl1 = '0;
        clear_oam();
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", sif.busy, 0);
        chk("reset done", sif.done, 0);
        chk("reset oam_addr", sif.oam_addr, 0);
        chk("reset on_tile0", sif.sprite_0_on_tile, 0);
        chk("reset on_tile1", sif.sprite_1_on_tile, 0);
        chk("reset overflow", sif.sprite_overflow, 0);
        rst = 1'b0;

        run_scan("empty", 100, 40, 1'b0, 1'b0, 1'b0);

        put(0, 50, 8'h12, 8'h41, 44);
        run_scan("oam0_hit", 53, 40, 1'b0, 1'b0, 1'b0);

        clear_oam();
        put(3, 10, 8'h33, 8'h03, 0);
        put(7, 10, 8'h77, 8'h07, 0);
        run_scan("neg_col_hits", 12, -4, 1'b0, 1'b0, 1'b0);
        put(3, 10, 8'h33, 8'h03, 4);
        put(7, 10, 8'h77, 8'h07, 4);
        run_scan("neg_col_miss", 12, -4, 1'b0, 1'b0, 1'b0);

        clear_oam();
        put(10, 100, 8'hA0, 8'h22, 50);
        run_scan("tall_row115", 115, 48, 1'b1, 1'b0, 1'b0);
        run_scan("tall_row116", 116, 48, 1'b1, 1'b0, 1'b0);
        run_scan("short_row108", 108, 48, 1'b0, 1'b0, 1'b0);

        clear_oam();
        put(1, 58, 8'h01, 8'h11, 80);
        put(2, 55, 8'h02, 8'h12, 84);
        put(5, 60, 8'h05, 8'h15, 73);
        run_scan("three_hits", 60, 80, 1'b0, 1'b0, 1'b1);

        // Back-to-back: start accepted in the cycle done is high; Y=0xFF must never wrap.
        clear_oam();
        run_scan("chain_yff", 0, 250, 1'b1, 1'b1, 1'b0);

        clear_oam();
        put(0, 50, 8'h12, 8'h41, 44);
        sif.curr_row = 9'd53;
        sif.curr_col = 9'd40;
        sif.ppu_ctrl1 = 8'h00;
        @(negedge clk);
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        chk("pre_rst on_tile0", sif.sprite_0_on_tile, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst busy", sif.busy, 0);
        chk("mid_rst done", sif.done, 0);
        chk("mid_rst oam_addr", sif.oam_addr, 0);
        chk("mid_rst on_tile0", sif.sprite_0_on_tile, 0);
        chk("mid_rst row0", sif.sprite_0_row, 0);
        chk("mid_rst is_oam0", sif.sprite_0_is_oam0, 0);
        $display("[TB] mid-scan reset applied at cycle 20");
        rst = 1'b0;
        run_scan("after_rst", 53, 40, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            row  = int'($urandom_range(239));
            col  = int'($urandom_range(262)) - 7;
            tall = 1'($urandom_range(1));
            for (int n = 0; n < 64; n++) begin
                if ($urandom_range(7) == 0) begin
                    y = row - int'($urandom_range(17)) + 1;
                    x = col + int'($urandom_range(20)) - 10;
                end else begin
                    y = ($urandom_range(1) == 0) ? 255 : int'($urandom_range(255));
                    x = int'($urandom_range(255));
                end
                if (y < 0) y = 0;
                if (y > 255) y = 255;
                if (x < 0) x = 0;
                if (x > 255) x = 255;
                put(n, y, int'($urandom_range(255)), int'($urandom_range(255)), x);
            end
            run_scan($sformatf("rand%0d", r), row, col, tall, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
